// File: rtl/axi4_mem_responder.sv
// AXI4 memory-mapped responder backed by an internal word array.
// Write (AW/W/B) and read (AR/R) run independent state machines. There are no IDs,
// so responses come back in order on each channel. Bad bursts still complete the
// full handshake, return SLVERR, never touch the array and read back as zero.
module axi4_mem_responder #(
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int C_S_AXI_DATA_WIDTH = 64,
    parameter int C_MEM_DEPTH_LOG2   = 10,
    parameter logic [C_S_AXI_ADDR_WIDTH-1:0] C_BASEADDR = '0
) (
    input  logic                              S_AXI_ACLK,
    input  logic                              S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [7:0]                        S_AXI_AWLEN,
    input  logic [2:0]                        S_AXI_AWSIZE,
    input  logic [1:0]                        S_AXI_AWBURST,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic [3:0]                        S_AXI_AWCACHE,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WLAST,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [7:0]                        S_AXI_ARLEN,
    input  logic [2:0]                        S_AXI_ARSIZE,
    input  logic [1:0]                        S_AXI_ARBURST,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic [3:0]                        S_AXI_ARCACHE,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RLAST,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY
);
    localparam int AW       = C_S_AXI_ADDR_WIDTH;
    localparam int DW       = C_S_AXI_DATA_WIDTH;
    localparam int NBYTES   = DW / 8;
    localparam int ADDR_LSB = $clog2(NBYTES);
    localparam int WIN_LSB  = C_MEM_DEPTH_LOG2 + ADDR_LSB;
    localparam int DEPTH    = 1 << C_MEM_DEPTH_LOG2;
    localparam logic [2:0] FULL_SIZE = 3'(ADDR_LSB);
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef logic [C_MEM_DEPTH_LOG2-1:0] idx_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    // The base is window-aligned, so the window test reduces to comparing the
    // bits above the window, and the word index is simply the bits inside it.
    function automatic logic burst_bad(input logic [AW-1:0] addr, input logic [2:0] size,
                                       input logic [1:0] burst);
        return (addr[AW-1:WIN_LSB] != C_BASEADDR[AW-1:WIN_LSB]) || (size != FULL_SIZE) || burst[1];
    endfunction

    // ---------------- write channel ----------------
    w_state_t   w_state_q;
    logic       awready_q, wready_q, bvalid_q;
    logic [1:0] bresp_q;
    idx_t       w_idx_q;
    logic [7:0] w_len_q, w_cnt_q;
    logic       w_fixed_q, w_bad_q, w_err_q;
    logic       w_beat, w_final, mem_we;

    assign w_beat  = wready_q & S_AXI_WVALID;
    assign w_final = (w_cnt_q == w_len_q);
    assign mem_we  = w_beat & ~w_bad_q;

    // Write FSM: accept AW, count W beats to len (WLAST only checked), then respond on B.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= OKAY;
            w_idx_q   <= '0;
            w_len_q   <= '0;
            w_cnt_q   <= '0;
            w_fixed_q <= 1'b0;
            w_bad_q   <= 1'b0;
            w_err_q   <= 1'b0;
        end else begin
            case (w_state_q)
                W_IDLE: begin
                    awready_q <= 1'b1;
                    if (S_AXI_AWVALID && awready_q) begin
                        awready_q <= 1'b0;
                        wready_q  <= 1'b1;
                        w_idx_q   <= S_AXI_AWADDR[WIN_LSB-1:ADDR_LSB];
                        w_len_q   <= S_AXI_AWLEN;
                        w_cnt_q   <= '0;
                        w_fixed_q <= (S_AXI_AWBURST == 2'b00);
                        w_bad_q   <= burst_bad(S_AXI_AWADDR, S_AXI_AWSIZE, S_AXI_AWBURST);
                        w_err_q   <= 1'b0;
                        w_state_q <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_beat) begin
                        w_cnt_q <= w_cnt_q + 8'd1;
                        if (!w_fixed_q) w_idx_q <= w_idx_q + 1'b1;
                        if (w_final) begin
                            wready_q  <= 1'b0;
                            bvalid_q  <= 1'b1;
                            bresp_q   <= (w_bad_q || w_err_q || !S_AXI_WLAST) ? SLVERR : OKAY;
                            w_state_q <= W_RESP;
                        end else if (S_AXI_WLAST) begin
                            w_err_q <= 1'b1;
                        end
                    end
                end
                W_RESP: begin
                    if (S_AXI_BREADY) begin
                        bvalid_q  <= 1'b0;
                        bresp_q   <= OKAY;
                        awready_q <= 1'b1;
                        w_state_q <= W_IDLE;
                    end
                end
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

    // ---------------- read channel ----------------
    r_state_t   r_state_q;
    logic       arready_q, rvalid_q, rlast_q;
    logic [1:0] rresp_q;
    idx_t       r_idx_q;
    logic [7:0] r_len_q, r_cnt_q;
    logic       r_fixed_q, r_bad_q;
    logic [DW-1:0] rd_word;

    // Read FSM: accept AR, present one beat per RREADY, flag the last by count.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rresp_q   <= OKAY;
            r_idx_q   <= '0;
            r_len_q   <= '0;
            r_cnt_q   <= '0;
            r_fixed_q <= 1'b0;
            r_bad_q   <= 1'b0;
        end else begin
            case (r_state_q)
                R_IDLE: begin
                    arready_q <= 1'b1;
                    if (S_AXI_ARVALID && arready_q) begin
                        arready_q <= 1'b0;
                        rvalid_q  <= 1'b1;
                        rlast_q   <= (S_AXI_ARLEN == 8'd0);
                        rresp_q   <= burst_bad(S_AXI_ARADDR, S_AXI_ARSIZE, S_AXI_ARBURST) ? SLVERR : OKAY;
                        r_idx_q   <= S_AXI_ARADDR[WIN_LSB-1:ADDR_LSB];
                        r_len_q   <= S_AXI_ARLEN;
                        r_cnt_q   <= '0;
                        r_fixed_q <= (S_AXI_ARBURST == 2'b00);
                        r_bad_q   <= burst_bad(S_AXI_ARADDR, S_AXI_ARSIZE, S_AXI_ARBURST);
                        r_state_q <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (S_AXI_RREADY) begin
                        if (rlast_q) begin
                            rvalid_q  <= 1'b0;
                            rlast_q   <= 1'b0;
                            rresp_q   <= OKAY;
                            arready_q <= 1'b1;
                            r_state_q <= R_IDLE;
                        end else begin
                            r_cnt_q <= r_cnt_q + 8'd1;
                            rlast_q <= ((r_cnt_q + 8'd1) == r_len_q);
                            if (!r_fixed_q) r_idx_q <= r_idx_q + 1'b1;
                        end
                    end
                end
                default: r_state_q <= R_IDLE;
            endcase
        end
    end

    // ---------------- storage ----------------
    // One array per byte lane so strobed writes stay independent; no reset, so
    // contents survive S_AXI_ARESETN. Reads are asynchronous: a same-cycle write
    // to the word being read lands at the edge, so the beat sees the old data.
    for (genvar gi = 0; gi < NBYTES; gi++) begin : g_lane
        logic [7:0] lane_mem [DEPTH];

        // Byte-lane write, gated by the beat's strobe bit.
        always_ff @(posedge S_AXI_ACLK) begin
            if (mem_we && S_AXI_WSTRB[gi]) lane_mem[w_idx_q] <= S_AXI_WDATA[gi*8 +: 8];
        end

        assign rd_word[gi*8 +: 8] = lane_mem[r_idx_q];
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RLAST   = rlast_q;
    assign S_AXI_RRESP   = rresp_q;
    assign S_AXI_RDATA   = (rvalid_q && !r_bad_q) ? rd_word : '0;

    // Sub-word address bits, protection and cache attributes carry no meaning here.
    wire unused_inputs = &{1'b0, S_AXI_AWPROT, S_AXI_AWCACHE, S_AXI_ARPROT, S_AXI_ARCACHE,
                           S_AXI_AWADDR[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0]};
endmodule

// File: tb/tb_axi4_mem_responder.sv
// Directed bench for axi4_mem_responder: a byte-level memory model predicts B
// responses and R beats, which are queued when stimulus is issued and popped as
// the responder answers.
module tb_axi4_mem_responder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] awaddr = '0, araddr = '0;
    logic [7:0]  awlen = '0, arlen = '0;
    logic [2:0]  awsize = '0, arsize = '0, awprot = '0, arprot = '0;
    logic [1:0]  awburst = '0, arburst = '0;
    logic [3:0]  awcache = '0, arcache = '0;
    logic        awvalid = 1'b0, arvalid = 1'b0, wvalid = 1'b0, wlast = 1'b0;
    logic        bready = 1'b0, rready = 1'b0;
    logic [63:0] wdata = '0;
    logic [7:0]  wstrb = '0;
    logic        awready, wready, bvalid, arready, rvalid, rlast;
    logic [1:0]  bresp, rresp;
    logic [63:0] rdata;

    always #5 clk = ~clk;

    axi4_mem_responder dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWLEN(awlen), .S_AXI_AWSIZE(awsize), .S_AXI_AWBURST(awburst),
        .S_AXI_AWPROT(awprot), .S_AXI_AWCACHE(awcache), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WLAST(wlast), .S_AXI_WVALID(wvalid),
        .S_AXI_WREADY(wready), .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARLEN(arlen), .S_AXI_ARSIZE(arsize), .S_AXI_ARBURST(arburst),
        .S_AXI_ARPROT(arprot), .S_AXI_ARCACHE(arcache), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RLAST(rlast), .S_AXI_RVALID(rvalid),
        .S_AXI_RREADY(rready)
    );

    typedef struct {
        logic [63:0] data;
        logic        last;
        logic [1:0]  resp;
    } rexp_t;

    int          errors = 0;
    int          checks = 0;
    logic [63:0] model [1024];
    logic [63:0] wtab [256];
    rexp_t       rq[$];
    logic [1:0]  bq[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic is_bad(input logic [31:0] a, input logic [2:0] s, input logic [1:0] b);
        return (a >= 32'h0000_2000) || (s != 3'd3) || (b == 2'b10) || (b == 2'b11);
    endfunction

    function automatic int beat_idx(input logic [31:0] a, input logic [1:0] b, input int i);
        int base;
        base = int'(a[12:3]);
        return (b == 2'b00) ? base : (base + i) % 1024;
    endfunction

    // Apply wtab[0..len] to the model and queue the expected B response.
    task automatic model_write(input logic [31:0] a, input int len, input logic [2:0] s,
                               input logic [1:0] b, input logic [7:0] strb, input bit last_err);
        int k;
        if (!is_bad(a, s, b)) begin
            for (int i = 0; i <= len; i++) begin
                k = beat_idx(a, b, i);
                for (int j = 0; j < 8; j++)
                    if (strb[j]) model[k][j*8 +: 8] = wtab[i][j*8 +: 8];
            end
        end
        bq.push_back((is_bad(a, s, b) || last_err) ? 2'b10 : 2'b00);
    endtask

    task automatic push_read(input logic [31:0] a, input int len, input logic [2:0] s, input logic [1:0] b);
        rexp_t e;
        for (int i = 0; i <= len; i++) begin
            e.data = is_bad(a, s, b) ? 64'd0 : model[beat_idx(a, b, i)];
            e.last = (i == len);
            e.resp = is_bad(a, s, b) ? 2'b10 : 2'b00;
            rq.push_back(e);
        end
    endtask

    // early < 0: WLAST on the final beat; otherwise WLAST only on beat 'early'.
    task automatic bus_write(input logic [31:0] a, input int len, input logic [2:0] s,
                             input logic [1:0] b, input logic [7:0] strb, input int early);
        int t;
        @(negedge clk);
        awaddr = a; awlen = 8'(len); awsize = s; awburst = b; awvalid = 1'b1;
        t = 0;
        while (!awready && t < 50) begin @(negedge clk); t++; end
        check("aw_handshake_in_time", 64'(t < 50), 64'd1);
        @(negedge clk);
        awvalid = 1'b0;
        check("wready_after_aw", 64'(wready), 64'd1);
        for (int i = 0; i <= len; i++) begin
            wdata = wtab[i]; wstrb = strb; wvalid = 1'b1;
            wlast = (early >= 0) ? (i == early) : (i == len);
            t = 0;
            while (!wready && t < 50) begin @(negedge clk); t++; end
            @(negedge clk);
        end
        wvalid = 1'b0; wlast = 1'b0;
        check("bvalid_after_last_w", 64'(bvalid), 64'd1);
        bready = 1'b1;
        check("bresp", 64'(bresp), 64'(bq.pop_front()));
        @(negedge clk);
        bready = 1'b0;
        check("awready_after_b", 64'(awready), 64'd1);
    endtask

    task automatic bus_read(input logic [31:0] a, input int len, input logic [2:0] s,
                            input logic [1:0] b, input bit toggle);
        int t, got;
        rexp_t e;
        @(negedge clk);
        araddr = a; arlen = 8'(len); arsize = s; arburst = b; arvalid = 1'b1;
        t = 0;
        while (!arready && t < 50) begin @(negedge clk); t++; end
        check("ar_handshake_in_time", 64'(t < 50), 64'd1);
        @(negedge clk);
        arvalid = 1'b0;
        check("rvalid_after_ar", 64'(rvalid), 64'd1);
        t = 0; got = 0;
        while (got <= len && t < 4 * len + 50) begin
            rready = toggle ? (t % 2 == 0) : 1'b1;
            if (rvalid && rready) begin
                e = rq.pop_front();
                check("rdata", rdata, e.data);
                check("rlast", 64'(rlast), 64'(e.last));
                check("rresp", 64'(rresp), 64'(e.resp));
                got++;
            end
            @(negedge clk);
            t++;
        end
        rready = 1'b0;
        check("r_beat_count", 64'(got), 64'(len + 1));
        check("arready_after_rlast", 64'(arready), 64'd1);
        check("rvalid_after_rlast", 64'(rvalid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset values, then ready one edge after release.
        repeat (3) @(negedge clk);
        check("rst_awready", 64'(awready), 64'd0);
        check("rst_wready", 64'(wready), 64'd0);
        check("rst_bvalid", 64'(bvalid), 64'd0);
        check("rst_arready", 64'(arready), 64'd0);
        check("rst_rvalid", 64'(rvalid), 64'd0);
        check("rst_rdata", rdata, 64'd0);
        rst_n = 1'b1;
        #1 check("awready_before_first_edge", 64'(awready), 64'd0);
        @(negedge clk);
        check("awready_after_first_edge", 64'(awready), 64'd1);
        check("arready_after_first_edge", 64'(arready), 64'd1);

        // Single-beat write then read.
        wtab[0] = 64'h1122334455667788;
        model_write(32'h10, 0, 3'd3, 2'b01, 8'hFF, 1'b0);
        bus_write(32'h10, 0, 3'd3, 2'b01, 8'hFF, -1);
        push_read(32'h10, 0, 3'd3, 2'b01);
        bus_read(32'h10, 0, 3'd3, 2'b01, 1'b0);

        // 16-beat INCR write, read back with RREADY toggling.
        for (int i = 0; i < 16; i++) wtab[i] = 64'(i);
        model_write(32'h100, 15, 3'd3, 2'b01, 8'hFF, 1'b0);
        bus_write(32'h100, 15, 3'd3, 2'b01, 8'hFF, -1);
        push_read(32'h100, 15, 3'd3, 2'b01);
        bus_read(32'h100, 15, 3'd3, 2'b01, 1'b1);

        // Byte strobes: only the low four lanes are cleared.
        wtab[0] = '1;
        model_write(32'h200, 0, 3'd3, 2'b01, 8'hFF, 1'b0);
        bus_write(32'h200, 0, 3'd3, 2'b01, 8'hFF, -1);
        wtab[0] = '0;
        model_write(32'h200, 0, 3'd3, 2'b01, 8'h0F, 1'b0);
        bus_write(32'h200, 0, 3'd3, 2'b01, 8'h0F, -1);
        push_read(32'h200, 0, 3'd3, 2'b01);
        bus_read(32'h200, 0, 3'd3, 2'b01, 1'b0);

        // Error bursts: SLVERR, array untouched.
        wtab[0] = 64'hA5A5_0000_0000_5A5A;
        model_write(32'h0, 0, 3'd3, 2'b01, 8'hFF, 1'b0);
        bus_write(32'h0, 0, 3'd3, 2'b01, 8'hFF, -1);
        wtab[0] = 64'hDEAD_BEEF_DEAD_BEEF;
        model_write(32'h2000, 0, 3'd3, 2'b01, 8'hFF, 1'b0);
        bus_write(32'h2000, 0, 3'd3, 2'b01, 8'hFF, -1);
        push_read(32'h0, 0, 3'd3, 2'b01);
        bus_read(32'h0, 0, 3'd3, 2'b01, 1'b0);
        push_read(32'h2000, 0, 3'd3, 2'b01);
        bus_read(32'h2000, 0, 3'd3, 2'b01, 1'b0);
        model_write(32'h10, 0, 3'd2, 2'b01, 8'hFF, 1'b0);
        bus_write(32'h10, 0, 3'd2, 2'b01, 8'hFF, -1);
        push_read(32'h10, 0, 3'd3, 2'b01);
        bus_read(32'h10, 0, 3'd3, 2'b01, 1'b0);
        for (int i = 0; i < 4; i++) wtab[i] = 64'hCAFE_0000 + 64'(i);
        model_write(32'h100, 3, 3'd3, 2'b10, 8'hFF, 1'b0);
        bus_write(32'h100, 3, 3'd3, 2'b10, 8'hFF, -1);
        // Early WLAST carries the array's current contents, so the words must read back unchanged.
        for (int i = 0; i < 4; i++) wtab[i] = model[32 + i];
        model_write(32'h100, 3, 3'd3, 2'b01, 8'hFF, 1'b1);
        bus_write(32'h100, 3, 3'd3, 2'b01, 8'hFF, 2);
        push_read(32'h100, 3, 3'd3, 2'b01);
        bus_read(32'h100, 3, 3'd3, 2'b01, 1'b0);

        // INCR wrapping past the last word, and a FIXED burst.
        for (int i = 0; i < 4; i++) wtab[i] = 64'h7700_0000 + 64'(i);
        model_write(32'h1FF8, 3, 3'd3, 2'b01, 8'hFF, 1'b0);
        bus_write(32'h1FF8, 3, 3'd3, 2'b01, 8'hFF, -1);
        push_read(32'h1FF8, 3, 3'd3, 2'b01);
        bus_read(32'h1FF8, 3, 3'd3, 2'b01, 1'b0);
        push_read(32'h0, 2, 3'd3, 2'b01);
        bus_read(32'h0, 2, 3'd3, 2'b01, 1'b1);
        for (int i = 0; i < 4; i++) wtab[i] = 64'h6600_0000 + 64'(i);
        model_write(32'h300, 3, 3'd3, 2'b00, 8'hFF, 1'b0);
        bus_write(32'h300, 3, 3'd3, 2'b00, 8'hFF, -1);
        push_read(32'h300, 0, 3'd3, 2'b01);
        bus_read(32'h300, 0, 3'd3, 2'b01, 1'b0);

        // Concurrent 64-beat read and write over the same words: reads see old data.
        for (int i = 0; i < 64; i++) wtab[i] = 64'hA000_0000 + 64'(i);
        model_write(32'h800, 63, 3'd3, 2'b01, 8'hFF, 1'b0);
        bus_write(32'h800, 63, 3'd3, 2'b01, 8'hFF, -1);
        push_read(32'h800, 63, 3'd3, 2'b01);
        for (int i = 0; i < 64; i++) wtab[i] = 64'hB000_0000 + 64'(i);
        model_write(32'h800, 63, 3'd3, 2'b01, 8'hFF, 1'b0);
        fork
            bus_write(32'h800, 63, 3'd3, 2'b01, 8'hFF, -1);
            bus_read(32'h800, 63, 3'd3, 2'b01, 1'b0);
        join
        push_read(32'h800, 63, 3'd3, 2'b01);
        bus_read(32'h800, 63, 3'd3, 2'b01, 1'b0);

        // Reset in the middle of both bursts.
        @(negedge clk);
        awaddr = 32'h400; awlen = 8'd3; awsize = 3'd3; awburst = 2'b01; awvalid = 1'b1;
        araddr = 32'h800; arlen = 8'd3; arsize = 3'd3; arburst = 2'b01; arvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; arvalid = 1'b0;
        check("mid_wready", 64'(wready), 64'd1);
        check("mid_rvalid", 64'(rvalid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_awready", 64'(awready), 64'd0);
        check("async_rst_wready", 64'(wready), 64'd0);
        check("async_rst_bvalid", 64'(bvalid), 64'd0);
        check("async_rst_arready", 64'(arready), 64'd0);
        check("async_rst_rvalid", 64'(rvalid), 64'd0);
        check("async_rst_rdata", rdata, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("awready_before_edge_after_rst", 64'(awready), 64'd0);
        @(posedge clk);
        #1 check("awready_one_edge_after_rst", 64'(awready), 64'd1);
        push_read(32'h800, 3, 3'd3, 2'b01);
        bus_read(32'h800, 3, 3'd3, 2'b01, 1'b0);
        push_read(32'h10, 0, 3'd3, 2'b01);
        bus_read(32'h10, 0, 3'd3, 2'b01, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
